ma_pipe: RTL

MA_PIPE -- requirements
Module: ma_pipe

---
 rtl/ma_pkg.sv | 32 +++
 rtl/ma_lane.sv | 103 ++++++++++
 rtl/ma_pipe.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ma_pkg.sv
// ma_pkg: shared types and helpers for the approximate-adder pipeline.
//   subtype_e : accurate-region adder style (ripple-carry or carry-lookahead)
//   calc_bw   : width of the border field for a given largest border
//   sat_add   : unsigned add that clamps at the all-ones value of a w-bit field
package ma_pkg;

  typedef enum logic [0:0] {
    SUB_RCA = 1'b0,
    SUB_CLA = 1'b1
  } subtype_e;

  // Border field must be able to hold 0..max_border.
  function automatic int calc_bw(input int max_border);
    return $clog2(max_border + 1);
  endfunction

  // Saturating add for fields up to 63 bits wide; operands arrive zero-extended.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    if (sum > lim) begin
      return lim[63:0];
    end else begin
      return sum[63:0];
    end
  endfunction

endpackage

// File: rtl/ma_lane.sv
// ma_lane: one lane of the approximate adder (purely combinational).
//   border : runtime width of the approximate (low) region, 0 = exact
//   a, b   : operands
//   approx : approximate sum (BITWIDTH+1 bits)
//   err    : |approx - exact|
// Low region: bit border-1 is forced to 0, bits below it to 1, no carry out.
// High region: a true add of the upper operand bits with carry-in 0.
module ma_lane
  import ma_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int BW       = 3,
  parameter int SUBTYPE  = 1
) (
  input  logic [BW-1:0]       border,
  input  logic [BITWIDTH-1:0] a,
  input  logic [BITWIDTH-1:0] b,
  output logic [BITWIDTH:0]   approx,
  output logic [BITWIDTH:0]   err
);

  logic [BITWIDTH-1:0] mask_s;
  logic [BITWIDTH-1:0] a_hi_s;
  logic [BITWIDTH-1:0] b_hi_s;
  logic [BITWIDTH:0]   low_s;
  logic [BITWIDTH:0]   hi_sum_s;
  logic [BITWIDTH:0]   exact_s;

  // Region masks: mask marks the approximate bits, low_s the forced-one fill.
  always_comb begin
    mask_s = '0;
    low_s  = '0;
    for (int i = 0; i < BITWIDTH; i++) begin
      if (i < int'(border)) begin
        mask_s[i] = 1'b1;
      end else begin
        mask_s[i] = 1'b0;
      end
      if ((i + 1) < int'(border)) begin
        low_s[i] = 1'b1;
      end else begin
        low_s[i] = 1'b0;
      end
    end
    // Zeroing the low bits means the high add sees no carry from below.
    a_hi_s = a & ~mask_s;
    b_hi_s = b & ~mask_s;
  end

  if (SUBTYPE == int'(SUB_RCA)) begin : g_rca
    logic [BITWIDTH:0] c_s;

    // Ripple-carry adder over the high region.
    always_comb begin
      c_s      = '0;
      hi_sum_s = '0;
      for (int i = 0; i < BITWIDTH; i++) begin
        hi_sum_s[i] = a_hi_s[i] ^ b_hi_s[i] ^ c_s[i];
        c_s[i+1]    = (a_hi_s[i] & b_hi_s[i]) | ((a_hi_s[i] ^ b_hi_s[i]) & c_s[i]);
      end
      hi_sum_s[BITWIDTH] = c_s[BITWIDTH];
    end
  end else begin : g_cla
    logic [BITWIDTH-1:0] g_s;
    logic [BITWIDTH-1:0] p_s;
    logic [BITWIDTH:0]   c_s;
    logic                term_s;

    // Flat carry-lookahead: c[i] = OR_j ( g[j] & p[j+1] & ... & p[i-1] ).
    always_comb begin
      g_s      = a_hi_s & b_hi_s;
      p_s      = a_hi_s ^ b_hi_s;
      c_s      = '0;
      term_s   = 1'b0;
      hi_sum_s = '0;
      for (int i = 1; i <= BITWIDTH; i++) begin
        for (int j = 0; j < i; j++) begin
          term_s = g_s[j];
          for (int k = j + 1; k < i; k++) begin
            term_s = term_s & p_s[k];
          end
          c_s[i] = c_s[i] | term_s;
        end
      end
      for (int i = 0; i < BITWIDTH; i++) begin
        hi_sum_s[i] = p_s[i] ^ c_s[i];
      end
      hi_sum_s[BITWIDTH] = c_s[BITWIDTH];
    end
  end

  // Merge regions, form the exact sum and the absolute error.
  always_comb begin
    approx  = hi_sum_s | low_s;
    exact_s = {1'b0, a} + {1'b0, b};
    if (approx >= exact_s) begin
      err = approx - exact_s;
    end else begin
      err = exact_s - approx;
    end
  end

endmodule

// File: rtl/ma_pipe.sv
// ma_pipe: two-stage, multi-lane approximate adder with error statistics.
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b  : operand beats, LANES lanes packed per beat
//   out_valid/out_ready/out_sum  : result beats, BITWIDTH+1 bits per lane
//   cfg_valid/cfg_ready/cfg_border/cfg_err : border update (only when drained)
//   border_q                     : active border
//   stat_clr/err_acc/smp_cnt     : saturating error sum and lane-result count
// Stage 1 holds operands plus the border they were accepted with; stage 2
// holds the results and per-lane error, so a beat never mixes borders.
module ma_pipe
  import ma_pkg::*;
#(
  parameter  int BITWIDTH       = 8,
  parameter  int LANES          = 2,
  parameter  int MAX_BORDER     = 4,
  parameter  int DEFAULT_BORDER = 2,
  parameter  int SUBTYPE        = 1,
  parameter  int ACC_W          = 32,
  localparam int BW             = calc_bw(MAX_BORDER)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*BITWIDTH-1:0]     in_a,
  input  logic [LANES*BITWIDTH-1:0]     in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*(BITWIDTH+1)-1:0] out_sum,
  input  logic                          cfg_valid,
  input  logic [BW-1:0]                 cfg_border,
  output logic                          cfg_ready,
  output logic                          cfg_err,
  output logic [BW-1:0]                 border_q,
  input  logic                          stat_clr,
  output logic [ACC_W-1:0]              err_acc,
  output logic [ACC_W-1:0]              smp_cnt
);

  localparam int SW     = BITWIDTH + 1;
  localparam int ESUM_W = SW + $clog2(LANES) + 1;

  logic                      s1_valid_q, s1_valid_d;
  logic [LANES*BITWIDTH-1:0] s1_a_q, s1_a_d;
  logic [LANES*BITWIDTH-1:0] s1_b_q, s1_b_d;
  logic [BW-1:0]             s1_border_q, s1_border_d;
  logic                      s2_valid_q, s2_valid_d;
  logic [LANES*SW-1:0]       out_sum_q, out_sum_d;
  logic [LANES*SW-1:0]       s2_err_q, s2_err_d;
  logic [BW-1:0]             border_d;
  logic                      cfg_err_q, cfg_err_d;
  logic [ACC_W-1:0]          err_acc_q, err_acc_d;
  logic [ACC_W-1:0]          smp_cnt_q, smp_cnt_d;

  logic                      s1_advance_s, s2_advance_s;
  logic                      in_ready_s, in_fire_s;
  logic                      cfg_ready_s, cfg_fire_s;
  logic                      out_valid_s, out_fire_s;
  logic [LANES*SW-1:0]       approx_s;
  logic [LANES*SW-1:0]       err_lane_s;
  logic [ESUM_W-1:0]         err_sum_s;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ma_lane #(
      .BITWIDTH (BITWIDTH),
      .BW       (BW),
      .SUBTYPE  (SUBTYPE)
    ) u_lane (
      .border (s1_border_q),
      .a      (s1_a_q[i*BITWIDTH +: BITWIDTH]),
      .b      (s1_b_q[i*BITWIDTH +: BITWIDTH]),
      .approx (approx_s[i*SW +: SW]),
      .err    (err_lane_s[i*SW +: SW])
    );
  end

  // Handshake decode; a config request takes the cycle away from operands.
  always_comb begin
    s2_advance_s = !s2_valid_q || out_ready;
    s1_advance_s = s1_valid_q && s2_advance_s;
    cfg_ready_s  = !s1_valid_q && !s2_valid_q;
    cfg_fire_s   = cfg_valid && cfg_ready_s;
    if (cfg_fire_s) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = !s1_valid_q || s2_advance_s;
    end
    in_fire_s   = in_valid && in_ready_s;
    // Masked during reset so no result handshake can happen in that cycle.
    out_valid_s = s2_valid_q && !rst;
    out_fire_s  = out_valid_s && out_ready;
  end

  // Next state of both pipeline stages.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_border_d = s1_border_q;
    s2_valid_d  = s2_valid_q;
    out_sum_d   = out_sum_q;
    s2_err_d    = s2_err_q;
    if (in_fire_s) begin
      s1_valid_d  = 1'b1;
      s1_a_d      = in_a;
      s1_b_d      = in_b;
      s1_border_d = border_q;
    end else if (s1_advance_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s1_advance_s) begin
      s2_valid_d = 1'b1;
      out_sum_d  = approx_s;
      s2_err_d   = err_lane_s;
    end else if (out_fire_s) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Border update with clamping, and the error statistics.
  always_comb begin
    border_d  = border_q;
    cfg_err_d = 1'b0;
    if (cfg_fire_s) begin
      if (cfg_border > BW'(MAX_BORDER)) begin
        border_d  = BW'(MAX_BORDER);
        cfg_err_d = 1'b1;
      end else begin
        border_d  = cfg_border;
        cfg_err_d = 1'b0;
      end
    end else begin
      border_d  = border_q;
      cfg_err_d = 1'b0;
    end

    err_sum_s = '0;
    for (int i = 0; i < LANES; i++) begin
      err_sum_s = err_sum_s + ESUM_W'(s2_err_q[i*SW +: SW]);
    end

    // Clear has priority; the coincident beat's error is dropped.
    if (stat_clr) begin
      err_acc_d = '0;
      smp_cnt_d = '0;
    end else if (out_fire_s) begin
      err_acc_d = ACC_W'(sat_add(64'(err_acc_q), 64'(err_sum_s), ACC_W));
      smp_cnt_d = ACC_W'(sat_add(64'(smp_cnt_q), 64'(LANES), ACC_W));
    end else begin
      err_acc_d = err_acc_q;
      smp_cnt_d = smp_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_border_q <= BW'(DEFAULT_BORDER);
      s2_valid_q  <= 1'b0;
      out_sum_q   <= '0;
      s2_err_q    <= '0;
      border_q    <= BW'(DEFAULT_BORDER);
      cfg_err_q   <= 1'b0;
      err_acc_q   <= '0;
      smp_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_border_q <= s1_border_d;
      s2_valid_q  <= s2_valid_d;
      out_sum_q   <= out_sum_d;
      s2_err_q    <= s2_err_d;
      border_q    <= border_d;
      cfg_err_q   <= cfg_err_d;
      err_acc_q   <= err_acc_d;
      smp_cnt_q   <= smp_cnt_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign cfg_ready = cfg_ready_s;
  assign out_valid = out_valid_s;
  assign out_sum   = out_sum_q;
  assign cfg_err   = cfg_err_q;
  assign err_acc   = err_acc_q;
  assign smp_cnt   = smp_cnt_q;

endmodule
